// File: rtl/gc_conf_source_if.sv
// Host write port and loader-side stream bundle for gc_conf_source.
// slave: the word source; master: host + GC loader side.
interface gc_conf_source_if #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                                wr_en;
  logic [ADDR_WIDTH-1:0]               wr_addr;
  logic [ITERATION_VARIABLE_WIDTH-1:0] wr_data;
  logic                                wr_last;
  logic                                conf_en;
  logic                                config_busy;
  logic                                config_done;
  logic [ITERATION_VARIABLE_WIDTH-1:0] conf_bus;
  logic                                pdone;
  logic [1:0]                          src_state;
  logic [ADDR_WIDTH-1:0]               rd_ptr;
  logic                                wr_err;
  logic                                underrun;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_last,
    input  conf_en, config_busy, config_done,
    output conf_bus, pdone, src_state,
    output rd_ptr, wr_err, underrun
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_last,
    output conf_en, config_busy, config_done,
    input  conf_bus, pdone, src_state,
    input  rd_ptr, wr_err, underrun
  );
endinterface

// File: rtl/gc_conf_source.sv
// Configuration-word source: host fills a word store, then the image is
// streamed to the GC loader one word per consume (conf_en & ~busy & ~done).
// Ports: conf_clk, reset (async, active-high), bus (gc_conf_source_if.slave:
//   wr_en/wr_addr/wr_data/wr_last, conf_en/config_busy/config_done in;
//   conf_bus/pdone/src_state/rd_ptr/wr_err/underrun out).
// Option: define GC_CONF_SRC_UNDERRUN_EN to saturate at the image end and
//   flag underrun; otherwise the stream wraps back to word 0.
module gc_conf_source #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input logic             conf_clk,
  input logic             reset,
  gc_conf_source_if.slave bus
);
  localparam int W  = ITERATION_VARIABLE_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  // One extra bit: a full image of DEPTH words needs count = DEPTH.
  logic [PW-1:0] count;
  logic [PW-1:0] ptr;
  logic          pdone_q;
  logic          wr_err_q;
  logic          underrun_q;

  logic          in_range;
  logic          wr_open;
  logic          wr_ok;
  logic          consume;
  logic          at_end;
  logic [PW-1:0] new_count;
  logic [W-1:0]  rd_word;

  assign in_range  = {1'b0, bus.wr_addr} < DEPTH_P;
  assign wr_open   = (state == IDLE) || (state == DONE);
  assign wr_ok     = bus.wr_en && wr_open && in_range;
  assign consume   = bus.conf_en && !bus.config_busy
                     && !bus.config_done;
  assign at_end    = (ptr == count);
  assign new_count = {1'b0, bus.wr_addr} + PW'(1);

  always_ff @(posedge conf_clk) begin
    if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    rd_word = '0;
    if (state == STREAM && ptr < count)
      rd_word = mem[ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      ptr        <= '0;
      pdone_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !(wr_open && in_range);
      case (state)
        IDLE: begin
          if (wr_ok && bus.wr_last) begin
            count   <= new_count;
            state   <= READY;
            pdone_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.conf_en) begin
            state <= STREAM;
            ptr   <= '0;
          end
        end
        STREAM: begin
          if (bus.config_done) begin
            state <= DONE;
          end else if (consume) begin
            if (!at_end) begin
              ptr <= ptr + PW'(1);
            end else begin
`ifdef GC_CONF_SRC_UNDERRUN_EN
              underrun_q <= 1'b1;
`else
              ptr <= '0;
`endif
            end
          end
        end
        DONE: begin
          // A host write restarts configuration; the write itself
          // behaves exactly like an IDLE write.
          if (bus.wr_en) begin
            state      <= IDLE;
            pdone_q    <= 1'b0;
            ptr        <= '0;
            count      <= '0;
            underrun_q <= 1'b0;
            if (wr_ok && bus.wr_last) begin
              count   <= new_count;
              state   <= READY;
              pdone_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.conf_bus  = rd_word;
  assign bus.pdone     = pdone_q;
  assign bus.src_state = state;
  assign bus.rd_ptr    = ptr[ADDR_WIDTH-1:0];
  assign bus.wr_err    = wr_err_q;
  assign bus.underrun  = underrun_q;
endmodule
